// File: rtl/ram_readback_streamer.sv
// Walks a block of RAM through a 1-cycle registered read port and streams each word out with its address.
// A running XOR of every transferred word is kept for verifying RAM contents.
module ram_readback_streamer #(
  parameter int WID_MEM   = 36,
  parameter int ADDR_W    = 10,
  parameter int DEPTH_MEM = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    word_count,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               busy,
  output logic               done,
  output logic [WID_MEM-1:0] checksum,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]    issue_left;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_addr;
  logic [WID_MEM-1:0] buf_data [2];
  logic [ADDR_W-1:0]  buf_addr [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         occ;

  logic               start_ok;
  logic               xfer;
  logic               issue;
  logic [1:0]         occ_next;
  logic [ADDR_W-1:0]  raddr_inc;

  // Output handshake: a word transfers on every rising edge where m_valid and m_ready
  // are both high; once m_valid rises, it and m_data/m_addr hold until that transfer.
  assign m_valid   = (occ != 2'd0);
  assign m_data    = buf_data[rd_ptr];
  assign m_addr    = buf_addr[rd_ptr];
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_FIN);
  assign dbg_state = state;

  assign start_ok  = (state == S_IDLE) && start;
  assign xfer      = m_valid && m_ready;

  // Buffer occupancy next cycle before any new issue; it equals in-flight plus
  // buffered words after this cycle's transfer, so it is also the credit count.
  assign occ_next  = occ + {1'b0, inflight} - {1'b0, xfer};
  assign issue     = (state == S_RUN) && (occ_next < 2'd2);
  assign raddr_inc = (raddr == ADDR_W'(DEPTH_MEM - 1)) ? '0 : raddr + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issue_left == (ADDR_W+1)'(1))) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_next == 2'd0) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read issue side: address register, remaining-read counter and the tag of the read in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      raddr         <= '0;
      issue_left    <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      inflight <= issue;
      if (start_ok) begin
        issue_left <= word_count;
        if (word_count != '0) begin
          raddr <= base_addr;
        end
      end else if (issue) begin
        raddr         <= raddr_inc;
        issue_left    <= issue_left - 1'b1;
        inflight_addr <= raddr;
      end
    end
  end

  // Two-entry skid buffer; rdata is captured the cycle after its read was issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_addr[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= rdata;
        buf_addr[wr_ptr] <= inflight_addr;
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum ^ m_data;
    end
  end

endmodule

// File: tb/tb_ram_readback_streamer.sv
// Bench for ram_readback_streamer: RAM model, queue-based reference of the expected word
// stream, one negedge compare process and directed plus randomized runs.
module tb_ram_readback_streamer;

  localparam int W     = 36;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [AW-1:0] m_addr;
  logic          busy;
  logic          done;
  logic [W-1:0]  checksum;
  logic [1:0]    dbg_state;

  ram_readback_streamer #(.WID_MEM(W), .ADDR_W(AW), .DEPTH_MEM(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .raddr(raddr), .rdata(rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .busy(busy),
    .done(done), .checksum(checksum), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  logic [W-1:0] ram [DEPTH];
  always @(posedge clk) rdata <= ram[raddr];

  // scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] got_addr_q[$];
  logic [W-1:0]  model_sum;
  logic [W-1:0]  ed;
  logic [AW-1:0] ea;
  logic [AW-1:0] off;
  logic [W-1:0]  prev_data;
  logic [AW-1:0] prev_addr;
  bit            prev_stall;
  bit            act;
  bit            mon_en;
  bit            exp_done;
  int            errors, checks;
  int            cyc;
  int            run_cnt, run_base, xfers;
  int            start_neg, done_exp_cyc, done_seen_cyc, done_pulses;
  int            first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
  int            ready_mode;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = ($urandom_range(0, 3) == 0);
    endcase
  end

  // compare process
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (!act) begin
        check("idle m_valid", m_valid, 0);
        check("idle busy", busy, 0);
        check("idle done", done, 0);
        prev_stall = 1'b0;
      end else begin
        exp_done = (done_exp_cyc == cyc);
        check("busy", busy, (xfers < run_cnt));
        check("done", done, exp_done);
        if (prev_stall) begin
          check("stall m_valid", m_valid, 1);
          check("stall m_data", m_data, prev_data);
          check("stall m_addr", m_addr, prev_addr);
        end
        if (run_cnt > 0 && run_cnt < DEPTH) begin
          off = raddr - AW'(run_base);
          check("credit window", (off >= xfers && off <= xfers + 2 && off <= run_cnt), 1);
        end
        if (m_valid && first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          check("first valid latency", cyc - start_neg, 2);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("extra word", m_valid, 0);
          end else begin
            ed = exp_q.pop_front();
            ea = exp_addr_q.pop_front();
            check("m_data", m_data, ed);
            check("m_addr", m_addr, ea);
            model_sum = model_sum ^ ed;
          end
          got_addr_q.push_back(m_addr);
          if (xfers == 0) first_xfer_cyc = cyc;
          last_xfer_cyc = cyc;
          xfers++;
          if (xfers == run_cnt) done_exp_cyc = cyc + 1;
        end
        if (done) begin
          done_pulses++;
          done_seen_cyc = cyc;
        end
        if (exp_done) begin
          check("checksum at done", checksum, model_sum);
          check("words left at done", exp_q.size(), 0);
          act = 1'b0;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_addr  = m_addr;
      end
    end
  end

  // driver tasks
  task automatic start_run(input int base, input int cnt);
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    got_addr_q.delete();
    for (int i = 0; i < cnt; i++) begin
      exp_addr_q.push_back(AW'((base + i) % DEPTH));
      exp_q.push_back(ram[(base + i) % DEPTH]);
    end
    model_sum       = '0;
    xfers           = 0;
    run_cnt         = cnt;
    run_base        = base;
    first_valid_cyc = -1;
    done_exp_cyc    = -1;
    done_seen_cyc   = -1;
    start           = 1'b1;
    base_addr       = AW'(base);
    word_count      = (AW+1)'(cnt);
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = AW'($urandom_range(0, DEPTH - 1));
    word_count = (AW+1)'($urandom_range(0, DEPTH));
    start_neg  = cyc + 1;
    if (cnt == 0) done_exp_cyc = start_neg;
    act = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (act && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (act) begin
      check("run timeout", act, 0);
      act = 1'b0;
    end
  endtask

  task automatic run(input int base, input int cnt, input int mode);
    ready_mode = mode;
    start_run(base, cnt);
    wait_done(cnt * 8 + 50);
  endtask

  initial begin
    int n;
    int pulses_before;
    logic [AW-1:0] raddr_before;
    errors = 0; checks = 0; cyc = 0; act = 1'b0; mon_en = 1'b0;
    done_pulses = 0; ready_mode = 0; prev_stall = 1'b0;
    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = W'(i);
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset raddr", raddr, 0);
    check("reset m_data", m_data, 0);
    check("reset m_addr", m_addr, 0);
    check("reset checksum", checksum, 0);
    check("reset m_valid", m_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    reset = 1'b1;

    run(0, 4, 0);
    check("base0 checksum", checksum, 36'h0);
    check("base0 back-to-back", last_xfer_cyc - first_xfer_cyc, 3);
    check("base0 done cycle", done_seen_cyc - start_neg, 6);
    check("base0 addr3", got_addr_q[3], 3);

    run(1022, 4, 0);
    check("wrap words", got_addr_q.size(), 4);
    check("wrap addr0", got_addr_q[0], 1022);
    check("wrap addr1", got_addr_q[1], 1023);
    check("wrap addr2", got_addr_q[2], 0);
    check("wrap addr3", got_addr_q[3], 1);
    check("wrap raddr end", raddr, 2);

    run(5, 3, 0);
    check("base5 checksum", checksum, 36'h4);
    repeat (3) @(posedge clk);
    #1 check("checksum hold", checksum, 36'h4);

    run(100, 8, 1);
    check("count8 transfers", got_addr_q.size(), 8);

    raddr_before = raddr;
    run(700, 0, 0);
    check("count0 raddr", raddr, raddr_before);
    check("count0 checksum", checksum, 36'h0);
    check("count0 done cycle", done_seen_cyc - start_neg, 0);

    pulses_before = done_pulses;
    ready_mode = 1;
    start_run(300, 16);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'd9; word_count = 11'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(16 * 8 + 50);
    check("restart words", got_addr_q.size(), 16);
    check("restart single done", done_pulses - pulses_before, 1);

    for (int i = 0; i < DEPTH; i++) ram[i] = W'({$urandom(), $urandom()});
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), $urandom_range(0, 2));
    end

    pulses_before = done_pulses;
    ready_mode = 0;
    start_run($urandom_range(0, DEPTH - 1), 16);
    n = 0;
    while (xfers < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("reached 5 transfers", (xfers >= 5), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    act = 1'b0;
    reset = 1'b1;
    check("abort m_valid", m_valid, 0);
    check("abort busy", busy, 0);
    check("abort checksum", checksum, 0);
    check("abort raddr", raddr, 0);
    repeat (3) @(posedge clk);
    #1 check("abort no done", done_pulses - pulses_before, 0);

    run($urandom_range(0, DEPTH - 1), DEPTH, 0);
    check("full sweep words", got_addr_q.size(), DEPTH);
    check("full sweep done cycle", done_seen_cyc - start_neg, DEPTH + 2);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
